sm4_blk_sched: RTL and testbench
================================

// Module: sm4_blk_sched
// PURPOSE
//  Block scheduler directly upstream of the iterative SM4 core. Accepts 128-bit plaintext blocks and keys
//  over a valid/ready handshake, re-arms the core per block (pulses core reset, holds SM4_EN high), waits for
//  the core's OUT_READY, registers the ciphertext and presents it downstream with valid/ack.
//  Optional CBC chaining sits between the input port and the core data input.
// PARAMETERS
//  RST_CYCLES  2   cycles CORE_RST_N is held low before each block (>=2: core clears its data regs on negedge)
//  TIMEOUT     64  max cycles in RUN without CORE_DONE before ERR is raised (core needs ~35)
// PORTS
//  CLK         in   1    clock, all flops posedge
//  RST_N       in   1    asynchronous active-low reset
//  IN_VALID    in   1    input block valid
//  IN_READY    out  1    scheduler can accept a block (high only in IDLE)
//  IN_BLOCK    in   128  plaintext, word 0 in [127:96]
//  IN_KEY      in   128  key, sampled with IN_BLOCK on handshake
//  IV          in   128  CBC initial vector (used only with SM4_CBC_EN)
//  IV_LOAD     in   1    load IV into chain register (honoured only in IDLE)
//  DOUT        out  128  ciphertext, held stable while DOUT_VALID
//  DOUT_VALID  out  1    ciphertext available
//  DOUT_ACK    in   1    downstream consumes DOUT
//  ERR         out  1    sticky core timeout flag
//  CORE_RST_N  out  1    to core RST_N
//  CORE_EN     out  1    to core SM4_EN
//  CORE_DATA   out  128  to core IN_DATA, registered
//  CORE_KEY    out  128  to core IN_KEY, registered
//  CORE_DOUT   in   128  from core OUT_DATA
//  CORE_DONE   in   1    from core OUT_READY
// BEHAVIOUR
//  Reset (RST_N low, async): state=IDLE, CORE_RST_N=0, CORE_EN=0, DOUT=0, DOUT_VALID=0, ERR=0,
//   CORE_DATA=0, CORE_KEY=0, chain=0, counter=0. IN_READY = (state==IDLE), hence 1 after reset.
//  FSM: IDLE -> CRST -> RUN -> HOLD -> IDLE.
//   IDLE: CORE_RST_N=0, CORE_EN=0. IN_VALID&IN_READY: CORE_DATA<=IN_BLOCK (CBC: ^chain), CORE_KEY<=IN_KEY,
//    cnt<=0, go CRST. IV_LOAD in same cycle as accept: chain<=IV applies first, XOR uses IV.
//   CRST: CORE_RST_N=0, CORE_EN=1; after RST_CYCLES cycles go RUN, cnt<=0.
//   RUN: CORE_RST_N=1, CORE_EN=1, CORE_DATA/KEY frozen. CORE_DONE=1: DOUT<=CORE_DOUT, DOUT_VALID<=1,
//    (CBC: chain<=CORE_DOUT), go HOLD. cnt==TIMEOUT-1 without DONE: ERR<=1, go IDLE, no output.
//   HOLD: CORE_EN=0 (core freezes, keeps result); DOUT_VALID=1 until DOUT_ACK, then DOUT_VALID<=0, go IDLE.
//    IN_READY low in HOLD: no new block before consumption (single-block buffer, no overwrite).
//  Latency accept->DOUT_VALID: 1 + RST_CYCLES + core latency (~35) + 1 capture. Throughput 1 block per ~40 cycles.
//  CORE_DONE outside RUN is ignored. IV_LOAD outside IDLE is ignored. ERR clears only on RST_N.
//  RST_N mid-block: block is dropped, DOUT_VALID falls immediately, core held in reset.
//  Counters: RST cnt and RUN cnt share one 7-bit counter, saturating, never wraps.
// CONFIGURATION
//  SM4_CBC_EN defined: CBC encrypt; CORE_DATA=IN_BLOCK^chain; chain updated per output; IV/IV_LOAD active.
//  SM4_CBC_EN undefined: ECB; CORE_DATA=IN_BLOCK; no chain register; IV/IV_LOAD ports present but unused.
// STRUCTURE
//  Shared package/header sm4_pkg: state encodings (IDLE/CRST/RUN/HOLD), SM4 block width 128,
//   FK constants and standard test vector constants for benches.
//  One sub-module: sm4_cbc_xor (chain register + XOR, instantiated only under SM4_CBC_EN).
// TESTING (bench instantiates sm4_blk_sched + real SM4 core)
//  ECB: key=pt=0123456789abcdeffedcba9876543210 -> DOUT=681edf34d206965e86b3e94f536e4246, latency <=40.
//  Back-to-back: 3 identical blocks, DOUT_ACK same cycle as valid -> 3 identical ciphertexts, IN_READY only in IDLE.
//  Backpressure: hold DOUT_ACK=0 for 20 cycles with IN_VALID=1 -> DOUT stable, IN_READY=0, no 2nd accept.
//  CBC (SM4_CBC_EN): IV=0, IV_LOAD, 2 blocks as above -> blk1=681edf34...4246, blk2=SM4(pt^blk1).
//  Timeout: force CORE_DONE=0 -> ERR=1 after TIMEOUT RUN cycles, state IDLE, DOUT_VALID stays 0.
//  Reset mid-RUN: RST_N low at round 10 -> all outputs at reset values, next block encrypts correctly.

Source files
------------

// File: rtl/sm4_pkg.sv
// sm4_pkg: shared types and constants for the SM4 block scheduler.
// Holds FSM encoding, widths, FK constants and the standard test vector.
package sm4_pkg;

  localparam int BLK_W = 128;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CRST,
    S_RUN,
    S_HOLD
  } state_t;

  localparam logic [BLK_W-1:0] SM4_FK =
    128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [BLK_W-1:0] SM4_TV_KEY =
    128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [BLK_W-1:0] SM4_TV_PT =
    128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [BLK_W-1:0] SM4_TV_CT =
    128'h681edf34_d206965e_86b3e94f_536e4246;

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sm4_blk_sched_if.sv
// sm4_blk_sched_if: block in / ciphertext out handshake bundle.
// slave is the scheduler side, master the upstream/downstream side.
interface sm4_blk_sched_if;
  import sm4_pkg::*;

  logic             IN_VALID;
  logic             IN_READY;
  logic [BLK_W-1:0] IN_BLOCK;
  logic [BLK_W-1:0] IN_KEY;
  logic [BLK_W-1:0] DOUT;
  logic             DOUT_VALID;
  logic             DOUT_ACK;

  modport master (
    output IN_VALID, IN_BLOCK, IN_KEY, DOUT_ACK,
    input  IN_READY, DOUT, DOUT_VALID
  );

  modport slave (
    input  IN_VALID, IN_BLOCK, IN_KEY, DOUT_ACK,
    output IN_READY, DOUT, DOUT_VALID
  );

endinterface

// File: rtl/sm4_cbc_xor.sv
// sm4_cbc_xor: CBC chain register and plaintext XOR.
// An IV load in the accept cycle takes effect on that same block.
module sm4_cbc_xor
  import sm4_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [BLK_W-1:0] iv,
  input  logic             upd,
  input  logic [BLK_W-1:0] upd_data,
  input  logic [BLK_W-1:0] blk_in,
  output logic [BLK_W-1:0] blk_out
);

  logic [BLK_W-1:0] chain;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chain <= '0;
    end else if (load) begin
      chain <= iv;
    end else if (upd) begin
      chain <= upd_data;
    end
  end

  assign blk_out = blk_in ^ (load ? iv : chain);

endmodule

// File: rtl/sm4_blk_sched.sv
// sm4_blk_sched: re-arms an iterative SM4 core per block, buffers one result.
// Define SM4_CBC_EN for CBC chaining; the default build is ECB.
module sm4_blk_sched
  import sm4_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  sm4_blk_sched_if.slave   bus,
  input  logic [BLK_W-1:0] IV,
  input  logic             IV_LOAD,
  output logic             ERR,
  output logic             CORE_RST_N,
  output logic             CORE_EN,
  output logic [BLK_W-1:0] CORE_DATA,
  output logic [BLK_W-1:0] CORE_KEY,
  input  logic [BLK_W-1:0] CORE_DOUT,
  input  logic             CORE_DONE
);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BLK_W-1:0] dout_q;
  logic             dout_valid_q;
  logic [BLK_W-1:0] core_in;
  logic             idle;
  logic             accept;

  assign idle   = (state == S_IDLE);
  assign accept = idle & bus.IN_VALID;

  assign bus.IN_READY   = idle;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = dout_valid_q;

`ifdef SM4_CBC_EN
  logic capture;
  assign capture = (state == S_RUN) & CORE_DONE;

  sm4_cbc_xor u_cbc (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (idle & IV_LOAD),
    .iv       (IV),
    .upd      (capture),
    .upd_data (CORE_DOUT),
    .blk_in   (bus.IN_BLOCK),
    .blk_out  (core_in)
  );
`else
  logic unused_cbc;
  assign unused_cbc = ^{IV, IV_LOAD};
  assign core_in    = bus.IN_BLOCK;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      CORE_RST_N   <= 1'b0;
      CORE_EN      <= 1'b0;
      CORE_DATA    <= '0;
      CORE_KEY     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            CORE_DATA <= core_in;
            CORE_KEY  <= bus.IN_KEY;
            CORE_EN   <= 1'b1;
            cnt       <= '0;
            state     <= S_CRST;
          end
        end
        S_CRST: begin
          cnt <= cnt_inc(cnt);
          if (cnt == RST_LAST) begin
            cnt        <= '0;
            CORE_RST_N <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt_inc(cnt);
          if (CORE_DONE) begin
            dout_q       <= CORE_DOUT;
            dout_valid_q <= 1'b1;
            CORE_EN      <= 1'b0;
            state        <= S_HOLD;
          end else if (cnt == RUN_LAST) begin
            // core hung: drop the block, keep the flag
            ERR        <= 1'b1;
            CORE_EN    <= 1'b0;
            CORE_RST_N <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (bus.DOUT_ACK) begin
            dout_valid_q <= 1'b0;
            CORE_RST_N   <= 1'b0;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_blk_sched.sv
// tb_sm4_blk_sched: scheduler bench with a behavioural iterative SM4 core.
// Scoreboard of expected ciphertexts; build with SM4_CBC_EN for CBC.
module tb_sm4_blk_sched;
  import sm4_pkg::*;

`ifdef SM4_CBC_EN
  localparam bit CBC_MODE = 1'b1;
`else
  localparam bit CBC_MODE = 1'b0;
`endif

  localparam logic [2047:0] SBOX = {
    128'hd690e9fe_cce13db7_16b614c2_28fb2c05,
    128'h2b679a76_2abe04c3_aa441326_49860699,
    128'h9c4250f4_91ef987a_33540b43_edcfac62,
    128'he4b31ca9_c908e895_80df94fa_758f3fa6,
    128'h4707a7fc_f37317ba_83593c19_e6854fa8,
    128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
    128'h1e240e5e_6358d1a2_25227c3b_01217887,
    128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
    128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1,
    128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
    128'h1df6e22e_8266ca60_c02923ab_0d534e6f,
    128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
    128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8,
    128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
    128'h8969974a_0c96777e_65b9f109_c56ec684,
    128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948
  };

  logic             clk;
  logic             rst_n;
  logic [BLK_W-1:0] iv;
  logic             iv_load;
  logic             err;
  logic             core_rst_n;
  logic             core_en;
  logic [BLK_W-1:0] core_data;
  logic [BLK_W-1:0] core_key;
  logic [BLK_W-1:0] core_dout;
  logic             core_done;

  sm4_blk_sched_if bus ();

  sm4_blk_sched dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .bus        (bus),
    .IV         (iv),
    .IV_LOAD    (iv_load),
    .ERR        (err),
    .CORE_RST_N (core_rst_n),
    .CORE_EN    (core_en),
    .CORE_DATA  (core_data),
    .CORE_KEY   (core_key),
    .CORE_DOUT  (core_dout),
    .CORE_DONE  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int j = 0; j < 4; j++)
      r[31-8*j -: 8] = SBOX[2047 - 8*int'(a[31-8*j -: 8]) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [127:0] sm4_enc(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [31:0]  k [36];
    logic [31:0]  x [36];
    logic [31:0]  ck;
    logic [31:0]  b;
    logic [127:0] mk;
    mk = key ^ SM4_FK;
    for (int i = 0; i < 4; i++) begin
      k[i] = mk[127-32*i -: 32];
      x[i] = pt[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++)
        ck[31-8*j -: 8] = 8'((4*i + j) * 7);
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
      x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10)
             ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // Behavioural core: ~34 cycles after reset release, result held when disabled.
  logic [5:0]       rnd;
  logic             done_q;
  logic [BLK_W-1:0] cdout_q;
  logic             stall;

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rnd     <= '0;
      done_q  <= 1'b0;
      cdout_q <= '0;
    end else if (core_en && !done_q) begin
      rnd <= rnd + 6'd1;
      if (rnd == 6'd33) begin
        done_q  <= 1'b1;
        cdout_q <= sm4_enc(core_data, core_key);
      end
    end
  end

  assign core_dout = cdout_q;
  assign core_done = done_q & ~stall;

  int               checks = 0;
  int               errors = 0;
  logic [BLK_W-1:0] exp_q [$];
  logic [BLK_W-1:0] chain_m;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk,
                                         input logic [127:0] key);
    return sm4_enc(blk ^ (CBC_MODE ? chain_m : '0), key);
  endfunction

  task automatic push_exp(input logic [127:0] e);
    exp_q.push_back(e);
    chain_m = e;
  endtask

  task automatic send(input logic [127:0] blk, input logic [127:0] key,
                      input logic ld);
    int n;
    n = 0;
    while (!bus.IN_READY && n < 100) begin
      tick();
      n++;
    end
    chkb("in_ready_wait", bus.IN_READY, 1'b1);
    bus.IN_VALID = 1'b1;
    bus.IN_BLOCK = blk;
    bus.IN_KEY   = key;
    iv_load      = ld;
    tick();
    bus.IN_VALID = 1'b0;
    iv_load      = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!bus.DOUT_VALID && lat < 100) begin
      tick();
      lat++;
    end
    chkb({tag, "_valid"}, bus.DOUT_VALID, 1'b1);
  endtask

  task automatic take(input string tag);
    logic [127:0] e;
    chkb({tag, "_sb"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    chk({tag, "_dout"}, bus.DOUT, e);
    bus.DOUT_ACK = 1'b1;
    tick();
    bus.DOUT_ACK = 1'b0;
    chkb({tag, "_drop"}, bus.DOUT_VALID, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    chkb({tag, "_in_ready"}, bus.IN_READY, 1'b1);
    chkb({tag, "_dout_valid"}, bus.DOUT_VALID, 1'b0);
    chk({tag, "_dout"}, bus.DOUT, '0);
    chkb({tag, "_err"}, err, 1'b0);
    chkb({tag, "_core_rst_n"}, core_rst_n, 1'b0);
    chkb({tag, "_core_en"}, core_en, 1'b0);
    chk({tag, "_core_data"}, core_data, '0);
    chk({tag, "_core_key"}, core_key, '0);
  endtask

  initial begin
    int           lat;
    int           n;
    int           sent;
    int           got;
    logic         saw;
    logic [127:0] r_blk;
    logic [127:0] r_key;

    rst_n        = 1'b0;
    stall        = 1'b0;
    iv           = '0;
    iv_load      = 1'b0;
    chain_m      = '0;
    bus.IN_VALID = 1'b0;
    bus.IN_BLOCK = '0;
    bus.IN_KEY   = '0;
    bus.DOUT_ACK = 1'b0;
    tick();
    tick();
    check_reset("por");
    rst_n = 1'b1;
    tick();

    // standard vector with latency bound
    send(SM4_TV_PT, SM4_TV_KEY, 1'b0);
    push_exp(SM4_TV_CT);
    wait_valid("ecb", lat);
    chkb("ecb_latency", lat >= 3 && lat <= 40, 1'b1);
    take("ecb");

    // distinct key and data
    r_blk = {$urandom, $urandom, $urandom, $urandom};
    r_key = {$urandom, $urandom, $urandom, $urandom};
    send(r_blk, r_key, 1'b0);
    push_exp(model(r_blk, r_key));
    wait_valid("rand", lat);
    take("rand");

    // back-to-back with immediate ack
    bus.IN_BLOCK = SM4_TV_PT;
    bus.IN_KEY   = SM4_TV_KEY;
    bus.IN_VALID = 1'b1;
    bus.DOUT_ACK = 1'b1;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 400 && got < 3; c++) begin
      chkb("b2b_ready_idle", bus.IN_READY, !(core_en || core_rst_n));
      if (bus.IN_VALID && bus.IN_READY) begin
        push_exp(model(SM4_TV_PT, SM4_TV_KEY));
        sent++;
      end
      if (bus.DOUT_VALID) begin
        if (exp_q.size() > 0) chk("b2b_dout", bus.DOUT, exp_q.pop_front());
        else chkb("b2b_sb", 1'b0, 1'b1);
        got++;
      end
      tick();
      if (sent == 3) bus.IN_VALID = 1'b0;
    end
    bus.IN_VALID = 1'b0;
    bus.DOUT_ACK = 1'b0;
    chkb("b2b_count", got == 3, 1'b1);
    tick();
    chkb("b2b_drained", exp_q.size() == 0, 1'b1);

    // backpressure: result held, no second accept
    send(SM4_TV_PT, SM4_TV_KEY, 1'b0);
    push_exp(model(SM4_TV_PT, SM4_TV_KEY));
    wait_valid("bp", lat);
    bus.IN_VALID = 1'b1;
    bus.IN_BLOCK = ~SM4_TV_PT;
    for (int c = 0; c < 20; c++) begin
      chk("bp_dout", bus.DOUT, exp_q[0]);
      chkb("bp_ready", bus.IN_READY, 1'b0);
      chkb("bp_valid", bus.DOUT_VALID, 1'b1);
      chkb("bp_core_en", core_en, 1'b0);
      tick();
    end
    bus.IN_VALID = 1'b0;
    take("bp");

    // chaining from IV=0 (plain ECB repeat when CBC is off)
    iv      = '0;
    chain_m = iv;
    send(SM4_TV_PT, SM4_TV_KEY, 1'b1);
    push_exp(model(SM4_TV_PT, SM4_TV_KEY));
    wait_valid("cbc1", lat);
    take("cbc1");
    send(SM4_TV_PT, SM4_TV_KEY, 1'b0);
    push_exp(model(SM4_TV_PT, SM4_TV_KEY));
    wait_valid("cbc2", lat);
    take("cbc2");

    // core hang: ERR after TIMEOUT RUN cycles, no output
    stall = 1'b1;
    send(SM4_TV_PT, SM4_TV_KEY, 1'b0);
    n   = 0;
    saw = 1'b0;
    while (!err && n < 200) begin
      if (bus.DOUT_VALID) saw = 1'b1;
      tick();
      n++;
    end
    chkb("to_err", err, 1'b1);
    chkb("to_cycles", n == 66, 1'b1);
    chkb("to_no_out", saw, 1'b0);
    chkb("to_idle", bus.IN_READY, 1'b1);
    chkb("to_core_rst", core_rst_n, 1'b0);
    stall = 1'b0;

    // ERR stays set across a good block
    send(SM4_TV_PT, SM4_TV_KEY, 1'b0);
    push_exp(model(SM4_TV_PT, SM4_TV_KEY));
    wait_valid("post_to", lat);
    take("post_to");
    chkb("err_sticky", err, 1'b1);

    // reset while the core is at round 10
    send(SM4_TV_PT, SM4_TV_KEY, 1'b0);
    n = 0;
    while (rnd != 6'd10 && n < 100) begin
      tick();
      n++;
    end
    chkb("mid_round10", rnd == 6'd10, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    tick();
    rst_n   = 1'b1;
    chain_m = '0;
    tick();
    send(SM4_TV_PT, SM4_TV_KEY, 1'b0);
    push_exp(SM4_TV_CT);
    wait_valid("after_rst", lat);
    take("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
